// File: rtl/actuator_scheduler.sv
// rtl/actuator_scheduler.sv - arbitrates manual/auto actuator requests and slews angle and reflector
// Manual wins ties and may preempt an auto slew; auto never preempts.
module actuator_scheduler #(
  parameter int STEP_CYCLES = 16,
  parameter int ANGLE_MAX   = 30,
  parameter int REFL_SETTLE = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       enable,
  input  logic       man_req,
  input  logic [4:0] man_angle,
  input  logic       man_refl,
  input  logic       auto_req,
  input  logic [4:0] auto_angle,
  input  logic       auto_refl,
  output logic       man_ack,
  output logic       auto_ack,
  output logic [4:0] angle_cmd,
  output logic       refl_cmd,
  output logic       busy,
  output logic       owner,
  output logic       done
);

  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int RCW = (REFL_SETTLE > 1) ? $clog2(REFL_SETTLE) : 1;

  localparam logic [SCW-1:0] STEP_RELOAD   = SCW'(STEP_CYCLES - 1);
  localparam logic [RCW-1:0] SETTLE_RELOAD = RCW'(REFL_SETTLE - 1);
  localparam logic [4:0]     ANGLE_LIMIT   = 5'(ANGLE_MAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLEW = 2'd1;
  localparam logic [1:0] ST_REFL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]     state,       state_n;
  logic [SCW-1:0] step_cnt,    step_cnt_n;
  logic [RCW-1:0] settle_cnt,  settle_cnt_n;
  logic [4:0]     tgt_angle,   tgt_angle_n;
  logic           tgt_refl,    tgt_refl_n;
  logic [4:0]     angle_cmd_n;
  logic           refl_cmd_n;
  logic           owner_n;
  logic           man_ack_n;
  logic           auto_ack_n;
  logic           done_n;

  function automatic logic [4:0] clamp_angle(input logic [4:0] a);
    return (a > ANGLE_LIMIT) ? ANGLE_LIMIT : a;
  endfunction

  always_comb begin
    state_n      = state;
    step_cnt_n   = step_cnt;
    settle_cnt_n = settle_cnt;
    tgt_angle_n  = tgt_angle;
    tgt_refl_n   = tgt_refl;
    angle_cmd_n  = angle_cmd;
    refl_cmd_n   = refl_cmd;
    owner_n      = owner;
    man_ack_n    = 1'b0;
    auto_ack_n   = 1'b0;
    done_n       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable && man_req) begin
          tgt_angle_n = clamp_angle(man_angle);
          tgt_refl_n  = man_refl;
          owner_n     = 1'b1;
          man_ack_n   = 1'b1;
          step_cnt_n  = STEP_RELOAD;
          state_n     = ST_SLEW;
        end else if (enable && auto_req) begin
          tgt_angle_n = clamp_angle(auto_angle);
          tgt_refl_n  = auto_refl;
          owner_n     = 1'b0;
          auto_ack_n  = 1'b1;
          step_cnt_n  = STEP_RELOAD;
          state_n     = ST_SLEW;
        end
      end

      ST_SLEW: begin
        // Preemption restarts the step timer from the angle already reached.
        if (!owner && man_req && enable) begin
          tgt_angle_n = clamp_angle(man_angle);
          tgt_refl_n  = man_refl;
          owner_n     = 1'b1;
          man_ack_n   = 1'b1;
          step_cnt_n  = STEP_RELOAD;
        end else if (angle_cmd == tgt_angle) begin
          state_n = ST_REFL;
          if (refl_cmd != tgt_refl) begin
            refl_cmd_n   = tgt_refl;
            settle_cnt_n = SETTLE_RELOAD;
          end else begin
            settle_cnt_n = '0;
          end
        end else if (step_cnt == '0) begin
          angle_cmd_n = (angle_cmd < tgt_angle) ? angle_cmd + 5'd1 : angle_cmd - 5'd1;
          step_cnt_n  = STEP_RELOAD;
        end else begin
          step_cnt_n = step_cnt - 1'b1;
        end
      end

      ST_REFL: begin
        if (settle_cnt == '0) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          settle_cnt_n = settle_cnt - 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state      <= ST_IDLE;
      step_cnt   <= '0;
      settle_cnt <= '0;
      tgt_angle  <= '0;
      tgt_refl   <= 1'b0;
      angle_cmd  <= '0;
      refl_cmd   <= 1'b0;
      owner      <= 1'b0;
      man_ack    <= 1'b0;
      auto_ack   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      step_cnt   <= step_cnt_n;
      settle_cnt <= settle_cnt_n;
      tgt_angle  <= tgt_angle_n;
      tgt_refl   <= tgt_refl_n;
      angle_cmd  <= angle_cmd_n;
      refl_cmd   <= refl_cmd_n;
      owner      <= owner_n;
      man_ack    <= man_ack_n;
      auto_ack   <= auto_ack_n;
      done       <= done_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_actuator_scheduler.sv
// tb/tb_actuator_scheduler.sv - randomized self-checking bench for actuator_scheduler
module tb_actuator_scheduler;

  localparam int STEP   = 16;
  localparam int AMAX   = 30;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       res;
  logic       enable;
  logic       man_req, man_refl, auto_req, auto_refl;
  logic [4:0] man_angle, auto_angle;
  logic       man_ack, auto_ack, refl_cmd, busy, owner, done;
  logic [4:0] angle_cmd;

  int checks = 0;
  int errors = 0;
  int cur_angle = 0;
  logic cur_refl = 1'b0;

  actuator_scheduler #(.STEP_CYCLES(STEP), .ANGLE_MAX(AMAX), .REFL_SETTLE(SETTLE)) dut (
    .clk(clk), .res(res), .enable(enable),
    .man_req(man_req), .man_angle(man_angle), .man_refl(man_refl),
    .auto_req(auto_req), .auto_angle(auto_angle), .auto_refl(auto_refl),
    .man_ack(man_ack), .auto_ack(auto_ack), .angle_cmd(angle_cmd),
    .refl_cmd(refl_cmd), .busy(busy), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0; enable = 1'b0; man_req = 1'b0; auto_req = 1'b0;
    tick();
    checks++;
    if ({angle_cmd, refl_cmd, busy, owner, man_ack, auto_ack, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got angle=%0d refl=%0d busy=%0d owner=%0d mack=%0d aack=%0d done=%0d want all 0",
               angle_cmd, refl_cmd, busy, owner, man_ack, auto_ack, done);
    end
    res = 1'b1; enable = 1'b1;
    cur_angle = 0; cur_refl = 1'b0;
  endtask

  // Present one request at IDLE, take the grant edge, then scramble the inputs.
  task automatic grant(input logic is_man, input int a, input logic r);
    enable = 1'b1;
    if (is_man) begin
      man_req = 1'b1; man_angle = 5'(a); man_refl = r;
    end else begin
      auto_req = 1'b1; auto_angle = 5'(a); auto_refl = r;
    end
    tick();
    man_req = 1'b0; auto_req = 1'b0;
    man_angle = 5'($urandom); auto_angle = 5'($urandom);
    man_refl = 1'($urandom); auto_refl = 1'($urandom);
  endtask

  // Reference timeline: a step every STEP cycles after grant, then reflector phase, then done.
  task automatic follow_move(input int start_a, input logic start_r, input int tgt_raw,
                             input logic tgt_r, input logic is_man, input bit inject_auto);
    int tgt, d, dir, done_at, steps, exp_a;
    logic exp_r;
    tgt = (tgt_raw > AMAX) ? AMAX : tgt_raw;
    d = (tgt > start_a) ? tgt - start_a : start_a - tgt;
    dir = (tgt > start_a) ? 1 : -1;
    done_at = STEP * d + 1 + ((tgt_r != start_r) ? SETTLE : 1);
    for (int n = 0; n <= done_at + 1; n++) begin
      if (n > 0) begin
        if (inject_auto) auto_req = (n < done_at);
        enable = 1'($urandom_range(0, 1));
        tick();
      end
      steps = n / STEP;
      if (steps > d) steps = d;
      exp_a = start_a + dir * steps;
      exp_r = (tgt_r != start_r && n >= STEP * d + 1) ? tgt_r : start_r;
      checks++;
      if (int'(angle_cmd) !== exp_a) begin
        errors++;
        $display("FAIL angle n=%0d got %0d want %0d", n, angle_cmd, exp_a);
      end
      checks++;
      if (angle_cmd > 5'(AMAX)) begin
        errors++;
        $display("FAIL angle_limit n=%0d got %0d want <= %0d", n, angle_cmd, AMAX);
      end
      checks++;
      if (refl_cmd !== exp_r) begin
        errors++;
        $display("FAIL refl n=%0d got %0d want %0d", n, refl_cmd, exp_r);
      end
      checks++;
      if (done !== (n == done_at)) begin
        errors++;
        $display("FAIL done n=%0d got %0d want %0d", n, done, (n == done_at));
      end
      checks++;
      if (busy !== (n <= done_at)) begin
        errors++;
        $display("FAIL busy n=%0d got %0d want %0d", n, busy, (n <= done_at));
      end
      checks++;
      if (owner !== is_man) begin
        errors++;
        $display("FAIL owner n=%0d got %0d want %0d", n, owner, is_man);
      end
      checks++;
      if (man_ack !== (n == 0 && is_man)) begin
        errors++;
        $display("FAIL man_ack n=%0d got %0d want %0d", n, man_ack, (n == 0 && is_man));
      end
      checks++;
      if (auto_ack !== (n == 0 && !is_man)) begin
        errors++;
        $display("FAIL auto_ack n=%0d got %0d want %0d", n, auto_ack, (n == 0 && !is_man));
      end
    end
    auto_req = 1'b0; enable = 1'b1;
    cur_angle = tgt; cur_refl = tgt_r;
  endtask

  task automatic test_auto_basic();
    test_reset();
    grant(1'b0, 3, 1'b0);
    follow_move(cur_angle, cur_refl, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    enable = 1'b1;
    man_req = 1'b1; man_angle = 5'd5; man_refl = 1'b0;
    auto_req = 1'b1; auto_angle = 5'd9; auto_refl = 1'b1;
    tick();
    man_req = 1'b0; auto_req = 1'b0;
    follow_move(cur_angle, cur_refl, 5, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_preempt();
    bit reached;
    test_reset();
    grant(1'b0, 10, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL preempt_auto_done cycle=%0d got %0d want 0", i, done);
      end
      if (angle_cmd == 5'd4) reached = 1'b1;
      else tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL preempt_reach got %0d want 4", angle_cmd);
    end
    man_req = 1'b1; man_angle = 5'd2; man_refl = 1'b0;
    tick();
    man_req = 1'b0;
    follow_move(4, 1'b0, 2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_refl();
    test_reset();
    grant(1'b1, 0, 1'b1);
    follow_move(0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_clamp();
    grant(1'b1, 29, cur_refl);
    follow_move(cur_angle, cur_refl, 29, cur_refl, 1'b1, 1'b0);
    grant(1'b1, 31, cur_refl);
    follow_move(cur_angle, cur_refl, 31, cur_refl, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit reached;
    test_reset();
    grant(1'b1, 10, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (angle_cmd == 5'd6) reached = 1'b1;
      else tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reset_mid_reach got %0d want 6", angle_cmd);
    end
    res = 1'b0;
    tick();
    res = 1'b1;
    checks++;
    if ({angle_cmd, refl_cmd, busy, owner, done} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid got angle=%0d refl=%0d busy=%0d owner=%0d done=%0d want all 0",
               angle_cmd, refl_cmd, busy, owner, done);
    end
    enable = 1'b0; auto_req = 1'b1; man_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({auto_ack, man_ack, busy, done} !== 4'd0) begin
        errors++;
        $display("FAIL enable_block cycle=%0d got ack=%0d busy=%0d done=%0d want 0",
                 i, auto_ack, busy, done);
      end
    end
    auto_req = 1'b0; enable = 1'b1;
    cur_angle = 0; cur_refl = 1'b0;
  endtask

  task automatic test_random();
    logic is_man, r;
    int a;
    for (int k = 0; k < 12; k++) begin
      is_man = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 31);
      r = 1'($urandom_range(0, 1));
      grant(is_man, a, r);
      follow_move(cur_angle, cur_refl, a, r, is_man, is_man);
    end
  endtask

  initial begin
    res = 1'b0; enable = 1'b0;
    man_req = 1'b0; man_angle = '0; man_refl = 1'b0;
    auto_req = 1'b0; auto_angle = '0; auto_refl = 1'b0;
    tick();
    test_reset();
    test_auto_basic();
    test_priority();
    test_preempt();
    test_refl();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
